// File: rtl/aes_core_scheduler_pkg.sv
// Shared types and constants for the AES core scheduler.
//   sched_state_t    : scheduler FSM states
//   AES_BLOCK_W      : AES key / data block width
//   DEF_STEP_HALF    : default number of cycles CONTINUE stays at each level
//   DEF_TIMEOUT_CYC  : default cycle limit in STEP / RELEASE before giving up
package aes_ctrl_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int DEF_STEP_HALF   = 2;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STEP,
    RESP,
    RELEASE
  } sched_state_t;

endpackage

// File: rtl/aes_core_scheduler_if.sv
// Bundle of every non-clock signal between the scheduler, its requesters
// and the AES core.
//   master : the scheduler's view (drives req_ready, resp_*, status, core controls)
//   slave  : the requester fabric / core view (drives req_*, resp_ready, AES_DONE, AES_MSG_DEC)
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high; valid must not depend on ready. req_ready is one-hot and
// only ever high in IDLE; resp_valid is one-hot on the granted requester and
// its data stays stable until that requester's resp_ready is seen high.
interface aes_core_scheduler_if import aes_ctrl_pkg::*; #(
  parameter int NUM_REQ = 2
) ();

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_msg;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0]             resp_ready;
  logic [AES_BLOCK_W-1:0]         resp_data;
  logic                           resp_err;
  logic                           busy;
  logic [IDW-1:0]                 grant_id;
  logic                           AES_START;
  logic                           CONTINUE;
  logic [AES_BLOCK_W-1:0]         AES_KEY;
  logic [AES_BLOCK_W-1:0]         AES_MSG_ENC;
  logic                           AES_DONE;
  logic [AES_BLOCK_W-1:0]         AES_MSG_DEC;
  sched_state_t                   dbg_state;

  modport master (
    input  req_valid, req_key, req_msg, resp_ready, AES_DONE, AES_MSG_DEC,
    output req_ready, resp_valid, resp_data, resp_err, busy, grant_id,
           AES_START, CONTINUE, AES_KEY, AES_MSG_ENC, dbg_state
  );

  modport slave (
    output req_valid, req_key, req_msg, resp_ready, AES_DONE, AES_MSG_DEC,
    input  req_ready, resp_valid, resp_data, resp_err, busy, grant_id,
           AES_START, CONTINUE, AES_KEY, AES_MSG_ENC, dbg_state
  );

endinterface

// File: rtl/aes_core_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : request vector
//   ptr_i     : index served last; search starts at ptr_i+1 and wraps
//   en_i      : when low, no grant is produced
//   gnt_o     : one-hot grant (all zero if nothing requested or disabled)
//   gnt_idx_o : encoded index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_idx_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    if (en_i) begin
      // Offsets 1..NUM_REQ visit every requester once, the last one served
      // being visited last.
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = IDW'((int'(ptr_i) + k) % NUM_REQ);
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          gnt_idx_o  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one stepped AES decryption core among NUM_REQ requesters.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus (master) : requester handshake, response handshake, status
//                  (busy, grant_id, dbg_state) and the core controls
//                  AES_START / CONTINUE / AES_KEY / AES_MSG_ENC in,
//                  AES_DONE / AES_MSG_DEC back.
// A job is granted round-robin in IDLE, the core is started and stepped by
// falling edges of CONTINUE until AES_DONE (or a timeout), the result is
// held for the winner, then the core is stepped back until AES_DONE drops.
module aes_core_scheduler import aes_ctrl_pkg::*; #(
  parameter int NUM_REQ     = 2,
  parameter int STEP_HALF   = DEF_STEP_HALF,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               CLK,
  input  logic               RESET_N,
  aes_core_scheduler_if.master bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(STEP_HALF + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  sched_state_t           state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [AES_BLOCK_W-1:0] msg_q, msg_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic                   err_q, err_d;
  logic                   cont_q, cont_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDW-1:0]         arb_idx;
  logic [AES_BLOCK_W-1:0] sel_key, sel_msg;
  logic                   half_done, tmo_hit;
  logic                   step_cont;
  logic [CW-1:0]          step_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .en_i      (state_q == IDLE),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    sel_key = '0;
    sel_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_key = bus.req_key[i*AES_BLOCK_W +: AES_BLOCK_W];
        sel_msg = bus.req_msg[i*AES_BLOCK_W +: AES_BLOCK_W];
      end
    end
  end

  // Step generator: cnt_q counts cycles spent at the current CONTINUE level.
  // START counts as the first high cycle, so the first falling edge lands
  // STEP_HALF cycles after START begins.
  assign half_done = (cnt_q == CW'(STEP_HALF - 1));
  assign step_cont = half_done ? ~cont_q : cont_q;
  assign step_cnt  = half_done ? '0 : cnt_q + CW'(1);
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    key_d   = key_q;
    msg_d   = msg_q;
    data_d  = data_q;
    err_d   = err_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        cont_d = 1'b1;
        cnt_d  = '0;
        tmo_d  = '0;
        if (|arb_gnt) begin
          key_d   = sel_key;
          msg_d   = sel_msg;
          grant_d = arb_idx;
          ptr_d   = arb_idx;
          state_d = START;
        end
      end
      START: begin
        cont_d  = step_cont;
        cnt_d   = step_cnt;
        tmo_d   = '0;
        state_d = STEP;
      end
      STEP: begin
        // A result arriving on the timeout cycle still counts as success.
        if (bus.AES_DONE) begin
          data_d  = bus.AES_MSG_DEC;
          err_d   = 1'b0;
          cont_d  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else if (tmo_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          cont_d  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cont_d = step_cont;
          cnt_d  = step_cnt;
          tmo_d  = tmo_q + TW'(1);
        end
      end
      RESP: begin
        cont_d = 1'b1;
        cnt_d  = '0;
        tmo_d  = '0;
        if (bus.resp_ready[grant_q]) state_d = RELEASE;
      end
      RELEASE: begin
        // Keep stepping the core until it reports it is back to waiting.
        if (!bus.AES_DONE || tmo_hit) begin
          cont_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cont_d = step_cont;
          cnt_d  = step_cnt;
          tmo_d  = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cont_q  <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.req_ready   = arb_gnt;
  assign bus.resp_valid  = (state_q == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign bus.resp_data   = data_q;
  assign bus.resp_err    = err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.AES_START   = (state_q == START) || (state_q == STEP) || (state_q == RESP);
  assign bus.CONTINUE    = cont_q;
  assign bus.AES_KEY     = key_q;
  assign bus.AES_MSG_ENC = msg_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: doc/aes_core_scheduler.md
Name: aes_core_scheduler

Overview:
- Shares one AES decryption core among NUM_REQ requesters.
- Arbitrates round-robin, latches the winner's key and ciphertext, and drives AES_START.
- Generates the CONTINUE falling-edge step pulses the core advances on, so software and switches are not needed to step it.
- Returns plaintext to the winner, then walks the core back to its waiting state. Sits between the requester fabric and the AES core.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
STEP_HALF, 2, cycles CONTINUE is held at each level (full step period = 2*STEP_HALF)
TIMEOUT_CYC, 4096, max cycles in STEP before the job is aborted with an error

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a job
req_ready  out  NUM_REQ  one-hot; job from i accepted when valid&ready
req_key  in  NUM_REQ*128  key, requester i at [i*128+:128]
req_msg  in  NUM_REQ*128  ciphertext, requester i at [i*128+:128]
resp_valid  out  NUM_REQ  one-hot; result for requester i
resp_ready  in  NUM_REQ  requester i takes the result
resp_data  out  128  decrypted message (0 on error)
resp_err  out  1  timeout flag, qualified by resp_valid
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_REQ)  current/last granted requester
AES_START  out  1  to core
CONTINUE  out  1  to core; core steps on falling edge
AES_KEY  out  128  latched key to core
AES_MSG_ENC  out  128  latched ciphertext to core
AES_DONE  in  1  from core
AES_MSG_DEC  in  128  from core

Behaviour:
- Reset (async on RESET_N low, any state, mid-job included):
  - state=IDLE; all outputs 0, except CONTINUE=1 (so the first drop is a clean falling edge).
  - rr pointer=NUM_REQ-1, so requester 0 wins first.
  - Key, message and counters cleared.
- IDLE:
  - req_ready is combinational one-hot to the first requester with req_valid high, searching from pointer+1 with wrap.
  - On handshake: latch key/msg into AES_KEY/AES_MSG_ENC, set grant_id and pointer=winner, go START.
  - No request: stay, req_ready=0.
- START: AES_START=1 (held through STEP), step counter cleared, timeout counter cleared, go STEP next cycle.
- STEP:
  - CONTINUE alternates, STEP_HALF cycles low then STEP_HALF cycles high, repeating.
  - Each high->low transition is one core step. The first low follows START.
  - AES_DONE sampled high → capture AES_MSG_DEC into resp_data, resp_err=0, go RESP. CONTINUE returns high and stays high.
  - Timeout counter increments each STEP cycle. At TIMEOUT_CYC-1 without AES_DONE: resp_data=0, resp_err=1, go RESP.
  - AES_DONE and timeout in the same cycle: success wins.
- RESP:
  - resp_valid[grant_id]=1; resp_data/resp_err held stable.
  - resp_ready[grant_id] high → clear resp_valid, AES_START=0, go RELEASE.
  - resp_ready of other indices is ignored.
- RELEASE:
  - AES_START=0; keep issuing CONTINUE steps (same timing as STEP) until AES_DONE is sampled low, then go IDLE with CONTINUE=1.
  - Same timeout applies; on expiry go IDLE anyway.
- Only one job is in flight at a time. req_ready=0 in every state except IDLE.
- A requester dropping req_valid mid-job has no effect; its result is still presented.
- Fairness:
  - After serving i, the next search starts at i+1 mod NUM_REQ.
  - A continuously requesting set is served strictly in rotation.
- Latency, idle to first step: handshake cycle, +1 START, +STEP_HALF to first falling edge.

Decomposition:
- Package aes_ctrl_pkg holds:
  - sched_state_t enum (IDLE, START, STEP, RESP, RELEASE).
  - AES_BLOCK_W=128.
  - Default STEP_HALF and TIMEOUT_CYC constants.
- One sub-module, rr_arbiter: parameterised NUM_REQ; inputs req vector, pointer, enable; outputs one-hot grant and encoded index. Purely combinational.
- Step generator and timeout counter stay in the top module.

Test Plan:
- Single job: requester 0, key 128'h000102030405060708090a0b0c0d0e0f, msg 128'h69c4e0d86a7b0430d8cdb78070b4c55a -> resp_valid=2'b01, resp_data=128'h00112233445566778899aabbccddeeff, resp_err=0, busy=0 after RELEASE.
- Contention: both req_valid high continuously, 4 jobs -> grant order 0,1,0,1; req_ready never has two bits set.
- Back-pressure: resp_ready held low 50 cycles -> resp_valid and resp_data stable, no CONTINUE edges, AES_START stays 1; release -> core returns to waiting, AES_DONE=0, then IDLE.
- Timeout: core model never asserts AES_DONE, TIMEOUT_CYC=64 -> resp_err=1, resp_data=0 on cycle 64 of STEP; next job still accepted.
- Reset mid-STEP: RESET_N low during step 10 -> outputs cleared the same cycle (async), CONTINUE=1; after release, requester 0 wins first.
- Step timing: STEP_HALF=3 -> CONTINUE falling edges exactly 6 cycles apart, first one 3 cycles after START.
